// File: rtl/wave_mixer_pkg.sv
// Shared types and helpers for the wave_mixer sample mixer.
// Holds the sequencer states, the accumulator sizing rule and the output saturator.
package wave_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    MAC,
    EMIT
  } state_e;

  localparam int unsigned SAT_W = 64;

  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    clip;
  } sat_t;

  // Wide enough for channels_p full-scale products plus one guard bit.
  function automatic int unsigned acc_width(input int unsigned w,
                                            input int unsigned g,
                                            input int unsigned n);
    return w + g + $clog2(n) + 1;
  endfunction

  function automatic sat_t sat_f(input logic signed [SAT_W-1:0] x,
                                 input int unsigned             w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_t                    r;
    hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (w - 1));
    r.value = x;
    r.clip  = 1'b0;
    if (x > hi) begin
      r.value = hi;
      r.clip  = 1'b1;
    end else if (x < lo) begin
      r.value = lo;
      r.clip  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle clock-enable every div_p cycles.
// The pulse sits in the last count so the first tick lands div_p cycles after reset.
module sample_tick_gen #(
  parameter int unsigned div_p = 256
) (
  input  logic clk_i,
  input  logic reset_n_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (div_p > 1) ? $clog2(div_p) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(div_p - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick_o = (count == LAST);

endmodule

// File: rtl/wave_mixer.sv
// N-channel gain-weighted mixer: snapshots all voices on a sample tick, accumulates
// one product per cycle, then saturates into a valid/ready output register.
module wave_mixer
  import wave_mixer_pkg::*;
#(
  parameter int unsigned width_p      = 24,
  parameter int unsigned channels_p   = 4,
  parameter int unsigned gain_width_p = 8,
  parameter int unsigned div_p        = 256
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [channels_p-1:0]              en_i,
  input  logic [channels_p*gain_width_p-1:0] gain_i,
  input  logic [channels_p*width_p-1:0]      data_i,
  input  logic [channels_p-1:0]              valid_i,
  output logic                               tick_o,
  output logic [width_p-1:0]                 data_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic                               clip_o,
  output logic                               underrun_o,
  output logic                               overrun_o
);

  localparam int unsigned ACC_W  = acc_width(width_p, gain_width_p, channels_p);
  localparam int unsigned PROD_W = width_p + gain_width_p + 1;
  localparam int unsigned IDX_W  = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(channels_p - 1);

  state_e                    state;
  state_e                    state_next;
  logic [IDX_W-1:0]          idx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   res;
  logic signed [PROD_W-1:0]  prod;
  logic signed [width_p-1:0] data_q [channels_p];
  logic [gain_width_p-1:0]   gain_q [channels_p];
  sat_t                      sat;
  logic                      unused_sat_hi;

  sample_tick_gen #(
    .div_p(div_p)
  ) u_tick (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .tick_o   (tick_o)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_next;
  end

  // NOTE: next-state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick_o) state_next = CAPTURE;
      CAPTURE: state_next = MAC;
      MAC:     if (idx == LAST_IDX) state_next = EMIT;
      EMIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Signed sample times zero-extended gain; the extra bit keeps the gain positive.
  assign prod = PROD_W'(data_q[idx]) * $signed(PROD_W'({1'b0, gain_q[idx]}));
  assign res  = acc >>> (gain_width_p - 1);
  assign sat  = sat_f(SAT_W'(res), width_p);
  assign unused_sat_hi = ^sat.value[SAT_W-1:width_p];

  // NOTE: the snapshot arrays are reset along with the rest of the datapath so
  // a reset landing mid-MAC never leaves X values feeding the multiplier.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx        <= '0;
      acc        <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      clip_o     <= 1'b0;
      underrun_o <= 1'b0;
      overrun_o  <= 1'b0;
      for (int unsigned c = 0; c < channels_p; c++) begin
        data_q[c] <= '0;
        gain_q[c] <= '0;
      end
    end else begin
      case (state)
        CAPTURE: begin
          for (int unsigned c = 0; c < channels_p; c++) begin
            data_q[c] <= (en_i[c] & valid_i[c]) ? data_i[c*width_p +: width_p] : '0;
            gain_q[c] <= gain_i[c*gain_width_p +: gain_width_p];
          end
          if (|(en_i & ~valid_i)) underrun_o <= 1'b1;
          acc <= '0;
          idx <= '0;
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx + 1'b1;
        end
        default: ;
      endcase

      // A new sample always wins; losing an unconsumed one is flagged.
      if (state == EMIT) begin
        data_o  <= sat.value[width_p-1:0];
        valid_o <= 1'b1;
        if (sat.clip)            clip_o    <= 1'b1;
        if (valid_o && !ready_i) overrun_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wave_mixer.sv
// Directed self-checking bench for wave_mixer at default parameters.
// Expected samples are hand-computed from the mix equation and saturation limits.
module tb_wave_mixer;
  import wave_mixer_pkg::*;

  localparam int W = 24;
  localparam int N = 4;
  localparam int G = 8;
  localparam int D = 256;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic [N-1:0]     en_i;
  logic [N*G-1:0]   gain_i;
  logic [N*W-1:0]   data_i;
  logic [N-1:0]     valid_i;
  logic             tick_o;
  logic [W-1:0]     data_o;
  logic             valid_o;
  logic             ready_i;
  logic             clip_o;
  logic             underrun_o;
  logic             overrun_o;

  int checks = 0;
  int errors = 0;
  int n;

  wave_mixer #(
    .width_p(W), .channels_p(N), .gain_width_p(G), .div_p(D)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (en_i),
    .gain_i    (gain_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .tick_o    (tick_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .clip_o    (clip_o),
    .underrun_o(underrun_o),
    .overrun_o (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] d, input logic [G-1:0] g);
    data_i[c*W +: W] = d;
    gain_i[c*G +: G] = g;
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk_i);
  endtask

  // Bounded wait for the next tick; also confirms the sequencer is idle then.
  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk_i);
      cnt++;
    end while (!tick_o && cnt < 1000);
    check("tick_seen", tick_o, 1'b1);
    check("tick_in_idle", dut.state == IDLE, 1'b1);
  endtask

  task automatic frame();
    int k;
    wait_tick(k);
    cyc(7);
  endtask

  task automatic check_flags(input string tag, input logic c, input logic u, input logic o);
    check({tag, "_clip"}, clip_o, c);
    check({tag, "_underrun"}, underrun_o, u);
    check({tag, "_overrun"}, overrun_o, o);
  endtask

  initial begin
    reset_n_i = 1'b0;
    en_i      = '0;
    valid_i   = '1;
    ready_i   = 1'b1;
    data_i    = '0;
    gain_i    = '0;
    cyc(10);
    check("reset_data", data_o, 0);
    check("reset_valid", valid_o, 0);
    check("reset_tick", tick_o, 0);
    check_flags("reset", 0, 0, 0);

    // Unity gain, single channel; also measures first tick and latency.
    for (int c = 0; c < N; c++) set_ch(c, 24'h000000, 8'd128);
    set_ch(0, 24'h100000, 8'd128);
    en_i      = 4'b0001;
    reset_n_i = 1'b1;
    wait_tick(n);
    check("first_tick_cycle", n, 255);
    cyc(6);
    check("latency_not_yet", valid_o, 0);
    cyc(1);
    check("latency_valid", valid_o, 1);
    check("unity_data", data_o, 24'h100000);
    check_flags("unity", 0, 0, 0);
    cyc(1);
    check("valid_drop_on_ready", valid_o, 0);
    wait_tick(n);
    check("tick_period", n, 248);
    cyc(7);
    check("unity_repeat", data_o, 24'h100000);

    // Four channels at +0.5 full scale overflow positively.
    for (int c = 0; c < N; c++) set_ch(c, 24'h400000, 8'd128);
    en_i = 4'hF;
    frame();
    check("sat_pos_data", data_o, 24'h7FFFFF);
    check_flags("sat_pos", 1, 0, 0);

    for (int c = 0; c < N; c++) set_ch(c, 24'h800000, 8'd255);
    frame();
    check("sat_neg_data", data_o, 24'h800000);

    set_ch(1, 24'h200000, 8'd64);
    en_i = 4'b0010;
    frame();
    check("gain_half_data", data_o, 24'h100000);

    en_i = 4'b0000;
    frame();
    check("silence_data", data_o, 0);
    check("silence_valid", valid_o, 1);

    // -0x101 * 64 = -0x4040; arithmetic shift by 7 floors to -0x81.
    set_ch(0, 24'hFFFEFF, 8'd64);
    en_i = 4'b0001;
    frame();
    check("neg_floor_data", data_o, 24'hFFFF7F);
    check("underrun_before", underrun_o, 0);

    set_ch(0, 24'h000100, 8'd128);
    set_ch(1, 24'h123456, 8'd128);
    en_i    = 4'b0011;
    valid_i = 4'b0001;
    frame();
    check("underrun_data", data_o, 24'h000100);
    check("underrun_set", underrun_o, 1);
    valid_i = 4'hF;
    en_i    = 4'b0001;
    frame();
    check("underrun_sticky", underrun_o, 1);

    // EMIT coinciding with a transfer: reload without overrun.
    cyc(1);
    check("drain_before_bp", valid_o, 0);
    ready_i = 1'b0;
    set_ch(0, 24'h000200, 8'd128);
    frame();
    check("bp_first_data", data_o, 24'h000200);
    set_ch(0, 24'h000400, 8'd128);
    wait_tick(n);
    cyc(6);
    check("same_cycle_pre", data_o, 24'h000200);
    ready_i = 1'b1;
    cyc(1);
    check("same_cycle_data", data_o, 24'h000400);
    check("same_cycle_valid", valid_o, 1);
    check("same_cycle_no_overrun", overrun_o, 0);
    cyc(1);
    check("same_cycle_drain", valid_o, 0);

    // Held output is overwritten by the next tick's sample.
    ready_i = 1'b0;
    set_ch(0, 24'h000200, 8'd128);
    frame();
    check("hold_first", data_o, 24'h000200);
    set_ch(0, 24'h000300, 8'd128);
    cyc(100);
    check("hold_stable_data", data_o, 24'h000200);
    check("hold_stable_valid", valid_o, 1);
    wait_tick(n);
    cyc(6);
    check("hold_before_emit", data_o, 24'h000200);
    cyc(1);
    check("overwrite_data", data_o, 24'h000300);
    check("overwrite_valid", valid_o, 1);
    check("overrun_set", overrun_o, 1);
    ready_i = 1'b1;
    cyc(1);
    check("overwrite_drain", valid_o, 0);

    // Reset in the middle of MAC clears everything immediately.
    set_ch(0, 24'h000500, 8'd128);
    wait_tick(n);
    cyc(3);
    check("in_mac", dut.state == MAC, 1'b1);
    reset_n_i = 1'b0;
    #1;
    check("midreset_data", data_o, 0);
    check("midreset_valid", valid_o, 0);
    check("midreset_tick", tick_o, 0);
    check_flags("midreset", 0, 0, 0);
    cyc(2);
    reset_n_i = 1'b1;
    wait_tick(n);
    check("post_reset_tick", n, 255);
    cyc(7);
    check("post_reset_data", data_o, 24'h000500);
    check("post_reset_valid", valid_o, 1);
    check_flags("post_reset", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
